// File: rtl/spi_pkg.sv
// Shared widths, frame layout and FSM encoding for the SPI write-frame controller.
package spi_pkg;

   localparam int unsigned FRAME_W  = 16;
   localparam int unsigned ADDR_W   = 7;
   localparam int unsigned DATA_W   = 8;
   localparam int unsigned NUM_REGS = 5;
   localparam logic        WRITE_FLAG = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } state_e;

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } frame_t;

   function automatic frame_t pack_frame(input logic [ADDR_W-1:0] addr,
                                         input logic [DATA_W-1:0] data);
      frame_t f;
      f.wr   = WRITE_FLAG;
      f.addr = addr;
      f.data = data;
      return f;
   endfunction

endpackage

// File: rtl/spi_ctrl_tx_if.sv
// System-side start/done handshake plus the SPI pins of the write-frame controller.
interface spi_ctrl_tx_if;
   import spi_pkg::*;

   logic              start;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              busy;
   logic              done;
   logic              err;
   logic              sclk;
   logic              sdo;
   logic              cs;

   modport master (
      output start, wr_addr, wr_data,
      input  busy, done, err, sclk, sdo, cs
   );

   modport slave (
      input  start, wr_addr, wr_data,
      output busy, done, err, sclk, sdo, cs
   );

endinterface

// File: rtl/spi_sclk_gen.sv
// sclk generator: CLK_DIV cycles per half-period while enabled, idles low when disabled.
// Tick strobes are combinational and mark the edge on which sclk toggles.
module spi_sclk_gen #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   output logic sclk_o,
   output logic rise_tick_c_o,
   output logic fall_tick_c_o
);

   localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sclk_q, sclk_d;
   logic             wrap_c;

   assign wrap_c        = en_i && (cnt_q == CNT_W'(CLK_DIV - 1));
   assign rise_tick_c_o = wrap_c && !sclk_q;
   assign fall_tick_c_o = wrap_c && sclk_q;
   assign sclk_o        = sclk_q;

   always_comb begin
      cnt_d  = '0;
      sclk_d = 1'b0;
      if (en_i) begin
         cnt_d  = wrap_c ? '0 : cnt_q + CNT_W'(1);
         sclk_d = wrap_c ? !sclk_q : sclk_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

endmodule

// File: rtl/spi_ctrl_tx.sv
// SPI mode-0 controller sending {write flag, addr, data} frames MSB first to the register peripheral.
// Build option SPI_ADDR_CHECK_EN: addresses >= NUM_REGS are dropped and flagged with an err pulse.
module spi_ctrl_tx
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned CS_SETUP = 2,
   parameter int unsigned CS_HOLD  = 2,
   parameter int unsigned CS_GAP   = 4
) (
   input  logic          clk,
   input  logic          rst,
   spi_ctrl_tx_if.slave  sys_if
);

   localparam int unsigned PH_MAX = (CS_SETUP > CS_HOLD)
                                    ? ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP)
                                    : ((CS_HOLD  > CS_GAP) ? CS_HOLD  : CS_GAP);
   localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
   localparam int unsigned BIT_W  = $clog2(FRAME_W);

   state_e             state_q, state_d;
   logic [PH_W-1:0]    ph_cnt_q, ph_cnt_d;
   logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic               last_q, last_d;
   logic [FRAME_W-1:0] shreg_q, shreg_d;
   logic               sdo_q, sdo_d;
   logic               cs_q, cs_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [FRAME_W-1:0] frame_c;
   logic               addr_bad_c;
   logic               accept_c;
   logic               rise_tick_c, fall_tick_c;

   spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
      .clk           (clk),
      .rst           (rst),
      .en_i          (state_q == SHIFT),
      .sclk_o        (sys_if.sclk),
      .rise_tick_c_o (rise_tick_c),
      .fall_tick_c_o (fall_tick_c)
   );

`ifdef SPI_ADDR_CHECK_EN
   logic err_q;

   assign addr_bad_c = (sys_if.wr_addr >= ADDR_W'(NUM_REGS));

   always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= (state_q == IDLE) && sys_if.start && addr_bad_c;
   end

   assign sys_if.err = err_q;
`else
   assign addr_bad_c = 1'b0;
   assign sys_if.err = 1'b0;
`endif

   assign frame_c  = pack_frame(sys_if.wr_addr, sys_if.wr_data);
   assign accept_c = (state_q == IDLE) && sys_if.start && !addr_bad_c;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // last_q arms the exit so the 16th falling edge ends SHIFT instead of shifting
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept_c) state_d = SETUP;
         SETUP:   if (ph_cnt_q == PH_W'(CS_SETUP - 1)) state_d = SHIFT;
         SHIFT:   if (fall_tick_c && last_q) state_d = HOLD;
         HOLD:    if (ph_cnt_q == PH_W'(CS_HOLD - 1)) state_d = GAP;
         GAP:     if (ph_cnt_q == PH_W'(CS_GAP - 1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ph_cnt_d  = '0;
      bit_cnt_d = '0;
      last_d    = 1'b0;
      shreg_d   = shreg_q;
      sdo_d     = sdo_q;
      cs_d      = !(state_d inside {SETUP, SHIFT, HOLD});
      busy_d    = (state_d != IDLE);
      done_d    = (state_q == GAP) && (state_d == IDLE);

      if ((state_d == state_q) && (state_q inside {SETUP, HOLD, GAP}))
         ph_cnt_d = ph_cnt_q + PH_W'(1);

      if (state_d == SHIFT) begin
         bit_cnt_d = bit_cnt_q;
         last_d    = last_q || (rise_tick_c && (bit_cnt_q == BIT_W'(FRAME_W - 1)));
         if ((state_q == SHIFT) && fall_tick_c) begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            shreg_d   = {shreg_q[FRAME_W-2:0], 1'b0};
            sdo_d     = shreg_q[FRAME_W-2];
         end
      end

      if (accept_c) begin
         shreg_d = frame_c;
         sdo_d   = frame_c[FRAME_W-1];
      end else if (cs_d) begin
         sdo_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ph_cnt_q  <= '0;
         bit_cnt_q <= '0;
         last_q    <= 1'b0;
         shreg_q   <= '0;
         sdo_q     <= 1'b0;
         cs_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         ph_cnt_q  <= ph_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         last_q    <= last_d;
         shreg_q   <= shreg_d;
         sdo_q     <= sdo_d;
         cs_q      <= cs_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign sys_if.sdo  = sdo_q;
   assign sys_if.cs   = cs_q;
   assign sys_if.busy = busy_q;
   assign sys_if.done = done_q;

endmodule
